// File: rtl/reg_view_pkg.sv
// reg_view_pkg: shared constants and helpers for the register view display
package reg_view_pkg;
  localparam int DIGITS = 8;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic int view_width(input int num_regs);
    return $clog2(num_regs + 1);
  endfunction
endpackage

// File: rtl/reg_view_display_btn_debounce.sv
// btn_debounce: synchronizes, debounces and edge-detects one raw push-button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q, sync_d;
  logic stable_q, stable_d, press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d = {sync_q[0], btn};
    stable_d = (sync_q[1] != stable_q && cnt_q == CNT_MAX) ? sync_q[1] : stable_q;
    cnt_d = (sync_q[1] == stable_q || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    press_d = stable_d & ~stable_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      stable_q <= 1'b0;
      cnt_q <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      press_q <= press_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/reg_view_display.sv
// reg_view_display: selects a register/PC view and shows it on a multiplexed 8-digit 7-segment display
module reg_view_display
  import reg_view_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REFRESH_DIV = 50_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_CYCLES = 50_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REGS-1:0][31:0] regs_in,
  input  logic [31:0]              pc_in,
  input  logic                     btn_next,
  input  logic                     btn_prev,
  input  logic                     auto_en,
  output logic [7:0]               an,
  output logic [6:0]               seg,
  output logic                     dp,
  output logic [4:0]               view_idx
);
  localparam int VW = view_width(NUM_REGS);
  localparam int PW = $clog2(REFRESH_DIV > 1 ? REFRESH_DIV : 2);
  localparam int AW = $clog2(AUTO_CYCLES > 1 ? AUTO_CYCLES : 2);
  localparam int DW = $clog2(DIGITS);
  localparam logic [VW-1:0] PC_VIEW = VW'(NUM_REGS);
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_CYCLES - 1);
  localparam logic [DW-1:0] LAST_DIG = DW'(DIGITS - 1);
  logic next_p, prev_p, tick, auto_tc, press_any, inc, dec, load;
  logic [VW-1:0] view_q, view_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [AW-1:0] auto_q, auto_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [31:0] snap_q, snap_d;
  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic [3:0] nib;
  logic [NUM_REGS:0][31:0] src;
  assign src = {pc_in, regs_in};
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .reset(reset), .btn(btn_next), .press(next_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk(clk), .reset(reset), .btn(btn_prev), .press(prev_p)
  );
  always_comb begin
    tick = pre_q == PRE_MAX;
    pre_d = tick ? '0 : pre_q + 1'b1;
    auto_tc = auto_en && auto_q == AUTO_MAX;
    press_any = next_p | prev_p;
    inc = (next_p & ~prev_p) | (auto_tc & ~press_any);
    dec = prev_p & ~next_p;
    view_d = inc ? (view_q == PC_VIEW ? '0 : view_q + 1'b1)
           : dec ? (view_q == '0 ? PC_VIEW : view_q - 1'b1) : view_q;
    auto_d = (!auto_en || press_any || auto_tc) ? '0 : auto_q + 1'b1;
    dig_d = tick ? dig_q + 1'b1 : dig_q;
    load = tick && dig_q == LAST_DIG;
    snap_d = load ? src[view_q] : snap_q;
    nib = snap_d[{dig_d, 2'b00} +: 4];
    an_d = tick ? ~(8'(1) << dig_d) : an_q;
    seg_d = tick ? HEX_SEG[nib] : seg_q;
    dp_d = tick ? !(dig_d == LAST_DIG && view_q == PC_VIEW) : dp_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      view_q <= '0;
      pre_q <= '0;
      auto_q <= '0;
      dig_q <= LAST_DIG;
      snap_q <= '0;
      an_q <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q <= 1'b1;
    end else begin
      view_q <= view_d;
      pre_q <= pre_d;
      auto_q <= auto_d;
      dig_q <= dig_d;
      snap_q <= snap_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign an = an_q;
  assign seg = seg_q;
  assign dp = dp_q;
  assign view_idx = 5'(view_q);
endmodule
